collision_detect: RTL and testbench
===================================

Name: collision_detect

Overview:
- Producer of the `collision` flag that the ball logic consumes at each frame boundary.
- Watches the pixel stream during the active area: the ball pixel, the left/right paddle pixels, and internally generated wall and goal bands.
- Accumulates overlaps over one frame, then classifies the frame's highest-priority hit.
- Publishes the result before vsync asserts, so the ball's frame-sync update sees a stable value.

Parameters:
- H_ACTIVE, 640, active pixels per line.
- V_ACTIVE, 480, active lines per frame.
- WALL_T, 8, thickness in lines of the top and bottom wall bands.
- GOAL_W, 20, width in pixels of the left and right goal bands.

Ports:
- clk  in  1  pixel clock
- reset  in  1  asynchronous, active-high reset
- hcount  in  10  current pixel column from the VGA timing block
- vcount  in  10  current line from the VGA timing block
- ball_pix  in  1  ball pixel lit; registered upstream, so it lags hcount/vcount by 1 clk
- lpad_pix  in  1  left paddle pixel lit; 1 clk lag
- rpad_pix  in  1  right paddle pixel lit; 1 clk lag
- collision  out  1  frame result, held constant for a whole frame
- hit_type  out  3  0 none, 1 top, 2 bottom, 3 lpad, 4 rpad, 5 lgoal, 6 rgoal
- hit_x  out  10  column of the first overlap pixel in the frame
- hit_y  out  10  line of the first overlap pixel in the frame
- hit_count  out  8  number of overlap pixels in the frame, saturating
- frame_done  out  1  1-clk pulse when the outputs update

Behaviour:
- Reset (asynchronous):
  - All outputs go to 0.
  - Accumulators clear and the delay pipeline clears.
  - State goes to ACCUM.
- Alignment:
  - hcount/vcount are delayed 1 clk internally into hd/vd.
  - Wall, goal and active-area decodes use hd/vd, so they line up with the registered pixel inputs.
- Band decodes (on hd/vd):
  - Active area: hd < H_ACTIVE and vd < V_ACTIVE.
  - top: vd < WALL_T.
  - bot: vd >= V_ACTIVE-WALL_T.
  - lgoal: hd < GOAL_W.
  - rgoal: hd >= H_ACTIVE-GOAL_W.
- Overlap cycle: ball_pix AND active AND (top, bot, lgoal, rgoal, lpad_pix or rpad_pix).
- On each overlap cycle:
  - Set the per-type sticky bit for every matching source.
  - Increment cnt, saturating at 255.
  - If this is the first overlap of the frame, capture hd/vd into fx/fy.
- Frame end strobe (fe) asserts for one clk on the rising edge of (vcount == V_ACTIVE and hcount == 0). The edge is detected against the registered previous value.
- State ACCUM:
  - Accumulate as above.
  - On fe, go to PUBLISH.
- State PUBLISH (1 clk):
  - Drive hit_type from the sticky bits by priority: lgoal > rgoal > top > bot > lpad > rpad.
  - collision = (hit_type != 0).
  - Load hit_x = fx, hit_y = fy, hit_count = cnt.
  - If there was no overlap, hit_x, hit_y and hit_count load 0.
  - Pulse frame_done.
  - Clear the sticky bits, cnt and the first-overlap flag.
  - Return to ACCUM.
- Outputs are registered and change only in PUBLISH or reset. They hold through vertical blanking and the whole next frame.
- Publish timing:
  - PUBLISH occurs 1 clk after fe, i.e. at the start of line V_ACTIVE.
  - This is well before vsync asserts, satisfying the consumer's sampling at vsync.
- Overlaps while hd/vd are outside the active area are ignored.
- Simultaneous overlap sources on one pixel set multiple sticky bits. Priority resolves them at publish.
- An overlap in the same clk as fe still counts toward the frame being closed. It cannot occur in practice because the pixel is outside the active area.
- Reset mid-frame: accumulation restarts from the current pixel. The partial frame publishes normally at the next fe.
- hit_count saturates at 255 and never wraps.

Optional Feature:
- Macro: COLLISION_DEBOUNCE_EN.
- When defined:
  - An internal register holds the last published non-zero hit_type.
  - If PUBLISH resolves the same non-zero type again, collision is forced to 0 and hit_type still reports the type.
  - A frame with no hit, or with a different type, clears or replaces the register.
  - This suppresses re-triggering while the ball remains inside a band for consecutive frames.
  - The register resets to 0.
- When undefined: collision = (hit_type != 0) every frame, with no extra state.

Test Plan:
- Ball pixel lit only at hd=320, vd=4 (top band) for a 3x3 block -> at next PUBLISH: collision=1, hit_type=1, hit_x=319, hit_y=3 (first pixel of the block), hit_count=9, frame_done pulsed once.
- Ball overlapping both lpad_pix and lgoal at hd=10, vd=200 -> hit_type=5 (goal beats paddle), collision=1.
- Ball lit with no overlapping source for a full frame -> collision=0, hit_type=0, hit_x=hit_y=hit_count=0. Previous values are replaced at PUBLISH, not before.
- Ball and rpad_pix overlapping for 300 pixels in one frame -> hit_count=255 (saturates), hit_type=4.
- Assert reset at vcount=100 after a top hit at line 4 -> outputs 0 immediately. A bot hit at line 475 then gives hit_type=2, and the top hit is not reported.
- With COLLISION_DEBOUNCE_EN, bot hits in two consecutive frames -> frame 1 gives collision=1; frame 2 gives collision=0 and hit_type=2. A third frame with no hit followed by a bot hit gives collision=1.

Source files
------------

// File: rtl/collision_detect_if.sv
// Pixel-stream inputs and per-frame collision results between the VGA pipeline and collision_detect.
// The slave modport is the detector's view; the master modport is the view of the stream source and result consumer.
interface collision_detect_if;
  logic [9:0] hcount;
  logic [9:0] vcount;
  logic       ball_pix;
  logic       lpad_pix;
  logic       rpad_pix;
  logic       collision;
  logic [2:0] hit_type;
  logic [9:0] hit_x;
  logic [9:0] hit_y;
  logic [7:0] hit_count;
  logic       frame_done;

  modport master (
    output hcount, vcount, ball_pix, lpad_pix, rpad_pix,
    input  collision, hit_type, hit_x, hit_y, hit_count, frame_done
  );

  modport slave (
    input  hcount, vcount, ball_pix, lpad_pix, rpad_pix,
    output collision, hit_type, hit_x, hit_y, hit_count, frame_done
  );
endinterface

// File: rtl/collision_detect.sv
// Per-frame ball collision classifier; results publish 1 clk after the frame-end strobe and hold for a frame.
// Optional COLLISION_DEBOUNCE_EN masks collision when the same non-zero hit type repeats in consecutive frames.
module collision_detect #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int WALL_T   = 8,
  parameter int GOAL_W   = 20
) (
  input  logic               clk,
  input  logic               reset,
  collision_detect_if.slave  bus
);

  localparam logic [9:0] H_LIM = 10'(H_ACTIVE);
  localparam logic [9:0] V_LIM = 10'(V_ACTIVE);
  localparam logic [9:0] TOP_LIM = 10'(WALL_T);
  localparam logic [9:0] BOT_LIM = 10'(V_ACTIVE - WALL_T);
  localparam logic [9:0] LG_LIM  = 10'(GOAL_W);
  localparam logic [9:0] RG_LIM  = 10'(H_ACTIVE - GOAL_W);

  typedef enum logic {ACCUM, PUBLISH} state_t;

  state_t     state, state_nx;
  logic       pub;

  logic [9:0] hd, vd;
  logic       eof, eof_q, fe;

  logic       active, top, bot, lgoal, rgoal;
  logic [5:0] hits;
  logic       ovl;

  logic [5:0] sticky;
  logic [7:0] cnt;
  logic [9:0] fx, fy;
  logic       seen;

  logic [2:0] type_nx;
  logic       coll_nx;

  // Pixel inputs arrive one clk late, so coordinates are delayed to match them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hd    <= '0;
      vd    <= '0;
      eof_q <= 1'b0;
    end else begin
      hd    <= bus.hcount;
      vd    <= bus.vcount;
      eof_q <= eof;
    end
  end

  assign eof = (bus.vcount == V_LIM) && (bus.hcount == 10'd0);
  assign fe  = eof && !eof_q;

  assign active = (hd < H_LIM) && (vd < V_LIM);
  assign top    = vd < TOP_LIM;
  assign bot    = vd >= BOT_LIM;
  assign lgoal  = hd < LG_LIM;
  assign rgoal  = hd >= RG_LIM;

  // Bit order doubles as priority order: lgoal, rgoal, top, bot, lpad, rpad.
  assign hits = {6{bus.ball_pix & active}} &
                {lgoal, rgoal, top, bot, bus.lpad_pix, bus.rpad_pix};
  assign ovl  = |hits;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ACCUM;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    pub      = 1'b0;
    case (state)
      ACCUM: begin
        if (fe) begin
          state_nx = PUBLISH;
        end
      end
      PUBLISH: begin
        pub      = 1'b1;
        state_nx = ACCUM;
      end
      default: state_nx = ACCUM;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sticky <= '0;
      cnt    <= '0;
      fx     <= '0;
      fy     <= '0;
      seen   <= 1'b0;
    end else if (pub) begin
      sticky <= '0;
      cnt    <= '0;
      fx     <= '0;
      fy     <= '0;
      seen   <= 1'b0;
    end else if (ovl) begin
      sticky <= sticky | hits;
      if (cnt != 8'hFF) begin
        cnt <= cnt + 8'd1;
      end
      if (!seen) begin
        fx   <= hd;
        fy   <= vd;
        seen <= 1'b1;
      end
    end
  end

  always_comb begin
    type_nx = 3'd0;
    if (sticky[5]) begin
      type_nx = 3'd5;
    end else if (sticky[4]) begin
      type_nx = 3'd6;
    end else if (sticky[3]) begin
      type_nx = 3'd1;
    end else if (sticky[2]) begin
      type_nx = 3'd2;
    end else if (sticky[1]) begin
      type_nx = 3'd3;
    end else if (sticky[0]) begin
      type_nx = 3'd4;
    end
  end

`ifdef COLLISION_DEBOUNCE_EN
  logic [2:0] last_type;

  // A no-hit frame stores 0, which re-arms the next hit of any type.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_type <= '0;
    end else if (pub) begin
      last_type <= type_nx;
    end
  end

  assign coll_nx = (type_nx != 3'd0) && (type_nx != last_type);
`else
  assign coll_nx = (type_nx != 3'd0);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.collision  <= 1'b0;
      bus.hit_type   <= '0;
      bus.hit_x      <= '0;
      bus.hit_y      <= '0;
      bus.hit_count  <= '0;
      bus.frame_done <= 1'b0;
    end else begin
      bus.frame_done <= pub;
      if (pub) begin
        bus.collision <= coll_nx;
        bus.hit_type  <= type_nx;
        bus.hit_x     <= seen ? fx  : 10'd0;
        bus.hit_y     <= seen ? fy  : 10'd0;
        bus.hit_count <= seen ? cnt : 8'd0;
      end
    end
  end

endmodule

// File: tb/tb_collision_detect.sv
// Randomized and directed frames against a queue-based per-frame reference model; a monitor checks every cycle.
module tb_collision_detect;

  localparam int H  = 640;
  localparam int V  = 480;
  localparam int WT = 8;
  localparam int GW = 20;

  logic clk = 1'b0;
  logic reset;

  collision_detect_if bus();

  collision_detect #(
    .H_ACTIVE (H),
    .V_ACTIVE (V),
    .WALL_T   (WT),
    .GOAL_W   (GW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       coll;
    logic [2:0] typ;
    logic [9:0] x;
    logic [9:0] y;
    logic [7:0] cnt;
  } res_t;

  typedef struct {
    int         h;
    int         v;
    logic [5:0] flags;
  } ov_t;

  res_t exp_q[$];
  ov_t  frame_ovs[$];
  res_t held;
  int   checks = 0;
  int   errors = 0;

  int   pend_h, pend_v;
  logic pend_b, pend_l, pend_r;
  logic prev_eof;
  logic [2:0] last_typ;

  function automatic res_t actual();
    return {bus.collision, bus.hit_type, bus.hit_x, bus.hit_y, bus.hit_count};
  endfunction

  task automatic check(input string name, input res_t got, input res_t want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got coll=%0b type=%0d x=%0d y=%0d cnt=%0d want coll=%0b type=%0d x=%0d y=%0d cnt=%0d at %0t",
               name, got.coll, got.typ, got.x, got.y, got.cnt,
               want.coll, want.typ, want.x, want.y, want.cnt, $time);
    end
  endtask

  // Reference: list every overlapping pixel of the frame, then summarise the list at frame end.
  function automatic void model_pixel(input int h, input int v, input logic b, input logic l, input logic r);
    logic [5:0] f;
    ov_t o;
    if (!b || h >= H || v >= V) return;
    f = {h < GW, h >= H - GW, v < WT, v >= V - WT, l, r};
    if (f != 6'd0) begin
      o.h = h;
      o.v = v;
      o.flags = f;
      frame_ovs.push_back(o);
    end
  endfunction

  function automatic void model_close();
    res_t r;
    logic [5:0] acc;
    int codes[6];
    codes = '{4, 3, 2, 1, 6, 5};
    r = '0;
    acc = '0;
    foreach (frame_ovs[i]) acc |= frame_ovs[i].flags;
    for (int b = 5; b >= 0; b--) begin
      if (acc[b]) begin
        r.typ = 3'(codes[b]);
        break;
      end
    end
    if (frame_ovs.size() > 0) begin
      r.x   = 10'(frame_ovs[0].h);
      r.y   = 10'(frame_ovs[0].v);
      r.cnt = (frame_ovs.size() > 255) ? 8'd255 : 8'(frame_ovs.size());
    end
    r.coll = (r.typ != 3'd0);
`ifdef COLLISION_DEBOUNCE_EN
    if (r.typ != 3'd0 && r.typ == last_typ) r.coll = 1'b0;
    last_typ = r.typ;
`endif
    exp_q.push_back(r);
    frame_ovs.delete();
  endfunction

  // One pixel clock: coordinates now, the previous coordinate's pixels alongside (1 clk lag).
  task automatic step(input int h, input int v, input logic b, input logic l, input logic r);
    logic eof;
    bus.hcount   = 10'(h);
    bus.vcount   = 10'(v);
    bus.ball_pix = pend_b;
    bus.lpad_pix = pend_l;
    bus.rpad_pix = pend_r;
    model_pixel(pend_h, pend_v, pend_b, pend_l, pend_r);
    eof = (h == 0 && v == V);
    if (eof && !prev_eof) model_close();
    prev_eof = eof;
    pend_h = h;
    pend_v = v;
    pend_b = b;
    pend_l = l;
    pend_r = r;
    @(posedge clk);
    #1;
  endtask

  task automatic end_frame();
    step(0, V, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i < 4; i++) step(i, V, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.ball_pix = 1'b0;
    bus.lpad_pix = 1'b0;
    bus.rpad_pix = 1'b0;
    pend_b = 1'b0;
    pend_l = 1'b0;
    pend_r = 1'b0;
    pend_h = 0;
    pend_v = 0;
    prev_eof = 1'b0;
    last_typ = '0;
    frame_ovs.delete();
    exp_q.delete();
    #1;
    check("reset_async", actual(), '0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  function automatic int pick_h();
    case ($urandom % 4)
      0:       return $urandom_range(29, 0);
      1:       return $urandom_range(340, 300);
      2:       return $urandom_range(650, 610);
      default: return $urandom_range(700, 0);
    endcase
  endfunction

  function automatic int pick_v();
    case ($urandom % 4)
      0:       return $urandom_range(12, 0);
      1:       return $urandom_range(400, 100);
      2:       return $urandom_range(490, 465);
      default: return $urandom_range(520, 0);
    endcase
  endfunction

  // Monitor: outputs must hold between publishes and match the model at each publish.
  initial begin
    held = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        held = '0;
        check("reset_hold", actual(), '0);
        checks++;
        if (bus.frame_done !== 1'b0) begin
          errors++;
          $display("FAIL reset_frame_done got %b want 0", bus.frame_done);
        end
      end else if (bus.frame_done === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame_done got pulse want none at %0t", $time);
        end else begin
          held = exp_q.pop_front();
          check("publish", actual(), held);
        end
      end else begin
        check("hold", actual(), held);
      end
    end
  end

  initial begin
    reset = 1'b0;
    bus.hcount = '0;
    bus.vcount = '0;
    bus.ball_pix = 1'b0;
    bus.lpad_pix = 1'b0;
    bus.rpad_pix = 1'b0;
    #2;
    do_reset();

    // 3x3 ball block in the top wall band.
    step(100, 3, 1'b0, 1'b0, 1'b0);
    for (int y = 3; y < 6; y++)
      for (int x = 319; x < 322; x++) step(x, y, 1'b1, 1'b0, 1'b0);
    step(400, 50, 1'b0, 1'b0, 1'b0);
    end_frame();

    // Goal band beats paddle on the same pixel.
    step(10, 200, 1'b1, 1'b1, 1'b0);
    step(200, 200, 1'b0, 1'b0, 1'b0);
    end_frame();

    // Ball lit with nothing to overlap.
    for (int i = 0; i < 20; i++) step(200 + i, 240, 1'b1, 1'b0, 1'b0);
    end_frame();

    // 300 right-paddle overlaps saturate the count.
    for (int i = 0; i < 300; i++) step(100 + (i % 400), 200 + i / 400, 1'b1, 1'b0, 1'b1);
    end_frame();

    // Reset mid-frame discards the earlier top hit.
    step(320, 4, 1'b1, 1'b0, 1'b0);
    step(321, 4, 1'b0, 1'b0, 1'b0);
    step(5, 100, 1'b0, 1'b0, 1'b0);
    do_reset();
    step(6, 100, 1'b0, 1'b0, 1'b0);
    step(300, 475, 1'b1, 1'b0, 1'b0);
    step(301, 475, 1'b0, 1'b0, 1'b0);
    end_frame();

    // Bottom hits in consecutive frames, a blank frame, then a bottom hit again.
    for (int f = 0; f < 4; f++) begin
      step(250, 476, (f != 2), 1'b0, 1'b0);
      step(251, 476, 1'b0, 1'b0, 1'b0);
      end_frame();
    end

    for (int f = 0; f < 40; f++) begin
      int n;
      n = 20 + int'($urandom % 60);
      for (int i = 0; i < n; i++)
        step(pick_h(), pick_v(), 1'($urandom % 2), 1'($urandom % 4 == 0), 1'($urandom % 4 == 0));
      end_frame();
    end

    step(5, 5, 1'b0, 1'b0, 1'b0);
    step(6, 5, 1'b0, 1'b0, 1'b0);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL unpublished_frames got %0d pending want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL timeout got no finish want finish");
    $fatal(1, "timeout");
  end

endmodule
